// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
// Command sequencer sitting directly in front of the 16-bit ALU. It parses
// byte frames from the UART RX path, loads the ALU operands and function code,
// and enables the ALU clock only for the operation window. It then captures the
// ALU result and returns it to the UART TX path as two bytes, low byte first.
//
// Frames:
//   CMD_ALU_OP  : opcode, A[7:0], A[15:8], B[7:0], B[15:8], FUN
//   CMD_ALU_NOP : opcode, FUN                (reuses the stored A and B)
//
// Ports:
//   CLK         system clock
//   RST         asynchronous reset, active-low
//   RX_P_DATA   received byte
//   RX_D_VLD    one-cycle strobe, RX_P_DATA valid
//   ALU_OUT     registered ALU result
//   ALU_A       ALU operand A
//   ALU_B       ALU operand B
//   ALU_FUN     ALU function select
//   ALU_CLK_EN  enable for the ALU clock-gating cell
//   TX_P_DATA   byte to transmit
//   TX_D_VLD    TX byte valid
//   TX_BUSY     TX cannot accept a byte while high
//   CMD_ERR     one-cycle error pulse
// -----------------------------------------------------------------------------
module alu_cmd_ctrl #(
   parameter int                DATA_W      = 8,
   parameter int                OPRND_W     = 16,
   parameter int                FUN_W       = 4,
   parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
   parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [DATA_W-1:0]  RX_P_DATA,
   input  logic               RX_D_VLD,
   input  logic [OPRND_W-1:0] ALU_OUT,
   output logic [OPRND_W-1:0] ALU_A,
   output logic [OPRND_W-1:0] ALU_B,
   output logic [FUN_W-1:0]   ALU_FUN,
   output logic               ALU_CLK_EN,
   output logic [DATA_W-1:0]  TX_P_DATA,
   output logic               TX_D_VLD,
   input  logic               TX_BUSY,
   output logic               CMD_ERR
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      GET_A0   = 4'd1,
      GET_A1   = 4'd2,
      GET_B0   = 4'd3,
      GET_B1   = 4'd4,
      GET_FUN  = 4'd5,
      ALU_RUN  = 4'd6,
      ALU_WAIT = 4'd7,
      TX_LO    = 4'd8,
      TX_HI    = 4'd9
   } state_t;

   // Highest function code the ALU implements; 0x0F and above are rejected.
   localparam logic [DATA_W-1:0] FUN_MAX = 8'h0E;

   state_t             state_r;
   logic [OPRND_W-1:0] result_r;

   // True when a received function byte selects an implemented ALU function.
   function automatic logic fun_ok(input logic [DATA_W-1:0] b);
      return (b <= FUN_MAX);
   endfunction

   // Frame parser, ALU window control and TX handshake; all outputs registered.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r    <= IDLE;
         result_r   <= {OPRND_W{1'b0}};
         ALU_A      <= {OPRND_W{1'b0}};
         ALU_B      <= {OPRND_W{1'b0}};
         ALU_FUN    <= {FUN_W{1'b0}};
         ALU_CLK_EN <= 1'b0;
         TX_P_DATA  <= {DATA_W{1'b0}};
         TX_D_VLD   <= 1'b0;
         CMD_ERR    <= 1'b0;
      end else begin
         // Pulses and the clock window are re-asserted explicitly each cycle.
         CMD_ERR    <= 1'b0;
         ALU_CLK_EN <= 1'b0;
         case (state_r)
            IDLE: begin
               if (RX_D_VLD) begin
                  if (RX_P_DATA == CMD_ALU_OP) begin
                     state_r <= GET_A0;
                  end else if (RX_P_DATA == CMD_ALU_NOP) begin
                     state_r <= GET_FUN;
                  end else begin
                     CMD_ERR <= 1'b1;
                  end
               end
            end
            GET_A0: begin
               if (RX_D_VLD) begin
                  ALU_A[DATA_W-1:0] <= RX_P_DATA;
                  state_r           <= GET_A1;
               end
            end
            GET_A1: begin
               if (RX_D_VLD) begin
                  ALU_A[OPRND_W-1:DATA_W] <= RX_P_DATA;
                  state_r                 <= GET_B0;
               end
            end
            GET_B0: begin
               if (RX_D_VLD) begin
                  ALU_B[DATA_W-1:0] <= RX_P_DATA;
                  state_r           <= GET_B1;
               end
            end
            GET_B1: begin
               if (RX_D_VLD) begin
                  ALU_B[OPRND_W-1:DATA_W] <= RX_P_DATA;
                  state_r                 <= GET_FUN;
               end
            end
            GET_FUN: begin
               if (RX_D_VLD) begin
                  if (fun_ok(RX_P_DATA)) begin
                     ALU_FUN    <= RX_P_DATA[FUN_W-1:0];
                     ALU_CLK_EN <= 1'b1;
                     state_r    <= ALU_RUN;
                  end else begin
                     CMD_ERR <= 1'b1;
                     state_r <= IDLE;
                  end
               end
            end
            ALU_RUN: begin
               // Second enabled cycle covers one cycle of gating-cell latency.
               CMD_ERR    <= RX_D_VLD;
               ALU_CLK_EN <= 1'b1;
               state_r    <= ALU_WAIT;
            end
            ALU_WAIT: begin
               CMD_ERR   <= RX_D_VLD;
               result_r  <= ALU_OUT;
               TX_P_DATA <= ALU_OUT[DATA_W-1:0];
               TX_D_VLD  <= 1'b1;
               state_r   <= TX_LO;
            end
            TX_LO: begin
               CMD_ERR <= RX_D_VLD;
               if (!TX_BUSY) begin
                  TX_D_VLD <= 1'b0;
                  state_r  <= TX_HI;
               end
            end
            TX_HI: begin
               // First cycle here is the mandatory idle gap after the low byte.
               CMD_ERR <= RX_D_VLD;
               if (!TX_D_VLD) begin
                  TX_P_DATA <= result_r[OPRND_W-1:DATA_W];
                  TX_D_VLD  <= 1'b1;
               end else if (!TX_BUSY) begin
                  TX_D_VLD <= 1'b0;
                  state_r  <= IDLE;
               end
            end
            default: begin
               state_r  <= IDLE;
               TX_D_VLD <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer directly upstream of the 16-bit ALU.
- Parses byte-wide command frames from the UART RX path and loads the ALU operands and function code.
- Gates the ALU clock on only for the operation window (low power), captures the ALU result, and streams it back to the UART TX path as two bytes.

Parameters:
DATA_W, 8, byte width of RX/TX data paths
OPRND_W, 16, ALU operand/result width (2 bytes)
FUN_W, 4, ALU function code width
CMD_ALU_OP, 8'hCC, frame opcode: load A, B, FUN then run
CMD_ALU_NOP, 8'hDD, frame opcode: reuse stored A, B; load FUN then run

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-low
RX_P_DATA  in  8  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
ALU_OUT  in  16  registered ALU result
ALU_A  out  16  ALU operand A
ALU_B  out  16  ALU operand B
ALU_FUN  out  4  ALU function select
ALU_CLK_EN  out  1  enable for the ALU clock-gating cell
TX_P_DATA  out  8  byte to transmit
TX_D_VLD  out  1  TX byte valid
TX_BUSY  in  1  TX cannot accept when high
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- Reset (RST low, async): state IDLE; ALU_A, ALU_B, result register = 0; ALU_FUN = 0; ALU_CLK_EN, TX_D_VLD, CMD_ERR = 0; TX_P_DATA = 0. All outputs registered.
- States: IDLE, GET_A0, GET_A1, GET_B0, GET_B1, GET_FUN, ALU_RUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE, on RX_D_VLD:
  - 0xCC -> GET_A0.
  - 0xDD -> GET_FUN.
  - Any other byte -> CMD_ERR pulse, stay IDLE.
- Operand states:
  - GET_A0 loads ALU_A[7:0]; GET_A1 loads ALU_A[15:8].
  - GET_B0 loads ALU_B[7:0]; GET_B1 loads ALU_B[15:8].
  - Each state advances only on RX_D_VLD. Low byte first.
- GET_FUN, on RX_D_VLD:
  - Byte <= 0x0E -> ALU_FUN = byte[3:0], go ALU_RUN.
  - Byte >= 0x0F -> CMD_ERR pulse, go IDLE. ALU_FUN unchanged, no ALU run, no TX.
- ALU_CLK_EN is high in exactly ALU_RUN and ALU_WAIT (2 cycles); low in all other states. This tolerates one cycle of gating-cell latency.
- Leaving ALU_WAIT, ALU_OUT is captured into the result register; go TX_LO.
- No arithmetic is done here. Result width is the ALU's 16 bits (product truncated, divide-by-zero value passed through unchanged).
- TX handshake:
  - A byte is accepted on a rising edge with TX_D_VLD=1 and TX_BUSY=0.
  - While waiting, TX_D_VLD and TX_P_DATA are held stable.
  - After each acceptance, TX_D_VLD is low for at least one cycle before the next byte is presented.
- TX_LO presents result[7:0], then goes to TX_HI. TX_HI presents result[15:8], then goes to IDLE.
- TX_BUSY has no timeout; backpressure is unbounded.
- ALU_A, ALU_B, ALU_FUN hold their values between frames. CMD_ALU_NOP reuses the last ALU_A and ALU_B.
- RX_D_VLD in ALU_RUN, ALU_WAIT, TX_LO or TX_HI: byte dropped, CMD_ERR pulse, no state or data change.
- A CMD_ERR pulse and a state transition in the same cycle are allowed. CMD_ERR is never high for 2 consecutive cycles unless 2 error bytes arrive back-to-back.
- RST asserted mid-frame or mid-TX: immediate return to reset values. The partial frame is discarded and no TX byte follows release.

Test Plan:
1. Frame CC,34,12,01,00,00 -> ALU_A=0x1234, ALU_B=0x0001, ALU_FUN=0, ALU_CLK_EN high 2 cycles; TX bytes 0x35 then 0x12; back to IDLE.
2. Then frame DD,02 -> operands reused, FUN=2; TX 0x34 then 0x12 (0x1234*1); no RX operand bytes consumed.
3. Frame CC,00,00,00,00,0F -> CMD_ERR pulse after 6th byte; ALU_CLK_EN never high; TX_D_VLD never high. Byte 0x55 in IDLE -> CMD_ERR pulse, stays IDLE.
4. TX_BUSY held high 20 cycles at TX_LO -> TX_D_VLD=1 with TX_P_DATA=0x35 stable throughout; accepted on first busy-low edge; TX_D_VLD low ≥1 cycle before 0x12 is presented.
5. RX_D_VLD with 0xCC during TX_HI -> CMD_ERR pulse, byte dropped; 0x12 still sent; next frame parses normally.
6. RST low after CC,34 -> all outputs 0 asynchronously; after release, bytes 12,01 -> two CMD_ERR pulses, no ALU run.
